ntt_stage_sequencer: RTL and testbench

- Controller that sequences one full forward NTT pass through the bank of P parallel butterfly units.
- Issues N/(2P) beats per stage for log2(N) stages and tags each beat with stage, beat and twiddle index.
- Inserts a drain gap after each stage equal to the butterfly pipeline latency, so the next stage never reads data that has not yet been written back.
- Sits between the top-level start/done handshake and the coefficient buffer read/write address logic.

---
 rtl/ntt_pkg.sv | 32 +++
 rtl/bf_tag_delay.sv | 30 +++
 rtl/ntt_stage_sequencer.sv | 144 ++++++++++++++
 tb/tb_ntt_stage_sequencer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared constants, FSM state type and butterfly tag payload for the NTT stage sequencer.
package ntt_pkg;

  localparam int unsigned N          = 4096;
  localparam int unsigned P          = 128;
  localparam int unsigned STAGES     = 12;
  localparam int unsigned BF_LATENCY = 8;
  localparam int unsigned BEATS      = N / (2 * P);
  localparam int unsigned BW         = $clog2(BEATS);
  localparam int unsigned SW         = $clog2(STAGES);
  localparam int unsigned DW         = $clog2(BF_LATENCY + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic          valid;
    logic [SW-1:0] stage;
    logic [BW-1:0] beat;
  } bf_tag_t;

  // Twiddle index: shift truncates to BW bits, which is the mod-BEATS wrap.
  function automatic logic [BW-1:0] tw_index(input logic [BW-1:0] beat,
                                             input logic [SW-1:0] stage);
    return beat << stage;
  endfunction

endpackage

// File: rtl/bf_tag_delay.sv
// Fixed-depth shift register that carries issue tags alongside the butterfly pipeline.
module bf_tag_delay
  import ntt_pkg::*;
#(
  parameter int unsigned DEPTH = BF_LATENCY
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    flush_i,
  input  bf_tag_t tag_i,
  output bf_tag_t tag_o
);

  bf_tag_t pipe_q [DEPTH];

  // Shifts unconditionally since the butterflies have no enable; flush drops in-flight tags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else if (flush_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= tag_i;
      for (int unsigned i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/ntt_stage_sequencer.sv
// Sequences one forward NTT pass: BEATS issues per stage, a BF_LATENCY drain gap between
// stages, and write-back tags delayed to line up with the butterfly outputs.
module ntt_stage_sequencer
  import ntt_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          stall,
  output logic          busy,
  output logic          issue_valid,
  output logic [SW-1:0] issue_stage,
  output logic [BW-1:0] issue_beat,
  output logic [BW-1:0] tw_idx,
  output logic          wb_valid,
  output logic [SW-1:0] wb_stage,
  output logic [BW-1:0] wb_beat,
  output logic          done
);

  seq_state_e    state_q, state_d;
  logic [SW-1:0] stage_q, stage_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  bf_tag_t       issue_q, issue_d;
  logic [BW-1:0] tw_q, tw_d;
  logic          flush_c;
  bf_tag_t       wb_tag;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      stage_q <= '0;
      beat_q  <= '0;
      drain_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      issue_q <= '0;
      tw_q    <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      beat_q  <= beat_d;
      drain_q <= drain_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      issue_q <= issue_d;
      tw_q    <= tw_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    beat_d  = beat_q;
    drain_d = drain_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    issue_d = '0;
    tw_d    = '0;
    flush_c = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_ISSUE;
          stage_d = '0;
          beat_d  = '0;
          busy_d  = 1'b1;
        end
      end
      S_ISSUE: begin
        busy_d = 1'b1;
        if (!stall) begin
          issue_d.valid = 1'b1;
          issue_d.stage = stage_q;
          issue_d.beat  = beat_q;
          tw_d          = tw_index(beat_q, stage_q);
          if (beat_q == BW'(BEATS - 1)) begin
            beat_d  = '0;
            drain_d = DW'(BF_LATENCY);
            state_d = S_DRAIN;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      S_DRAIN: begin
        busy_d  = 1'b1;
        drain_d = drain_q - DW'(1);
        if (drain_q == DW'(1)) begin
          if (stage_q == SW'(STAGES - 1)) begin
            state_d = S_DONE;
          end else begin
            stage_d = stage_q + SW'(1);
            state_d = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything above and discards in-flight write-back tags.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      stage_d = '0;
      beat_d  = '0;
      drain_d = '0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      issue_d = '0;
      tw_d    = '0;
      flush_c = 1'b1;
    end
  end

  bf_tag_delay #(
    .DEPTH (BF_LATENCY)
  ) u_tag_delay (
    .clk     (clk),
    .rst_n   (rst),
    .flush_i (flush_c),
    .tag_i   (issue_q),
    .tag_o   (wb_tag)
  );

  assign busy        = busy_q;
  assign done        = done_q;
  assign issue_valid = issue_q.valid;
  assign issue_stage = issue_q.stage;
  assign issue_beat  = issue_q.beat;
  assign tw_idx      = tw_q;
  assign wb_valid    = wb_tag.valid;
  assign wb_stage    = wb_tag.stage;
  assign wb_beat     = wb_tag.beat;

endmodule

// File: tb/tb_ntt_stage_sequencer.sv
// Directed bench for ntt_stage_sequencer: full passes, stall, abort, async reset, ignored starts.
module tb_ntt_stage_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic       stall;
  logic       busy;
  logic       issue_valid;
  logic [3:0] issue_stage;
  logic [3:0] issue_beat;
  logic [3:0] tw_idx;
  logic       wb_valid;
  logic [3:0] wb_stage;
  logic [3:0] wb_beat;
  logic       done;

  int n_checks = 0;
  int n_errors = 0;

  ntt_stage_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .stall       (stall),
    .busy        (busy),
    .issue_valid (issue_valid),
    .issue_stage (issue_stage),
    .issue_beat  (issue_beat),
    .tw_idx      (tw_idx),
    .wb_valid    (wb_valid),
    .wb_stage    (wb_stage),
    .wb_beat     (wb_beat),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected issue slot at cycle c: stage s beat b at 1 + s*24 + b, shifted by st_len
  // for every beat whose nominal slot falls on or after the first stalled edge.
  function automatic void exp_issue(input int c, input int st_edge, input int st_len,
                                    output bit v, output int s, output int b);
    v = 1'b0; s = 0; b = 0;
    for (int ss = 0; ss < 12; ss++) begin
      for (int bb = 0; bb < 16; bb++) begin
        int t = 1 + ss * 24 + bb;
        if (st_len > 0 && t >= st_edge) t += st_len;
        if (t == c) begin v = 1'b1; s = ss; b = bb; end
      end
    end
  endfunction

  // Start is sampled at edge 0; outputs for cycle c are sampled 1 time unit after edge c.
  task automatic run_pass(input int st_edge, input int st_len, input bit extra_starts);
    int  dc = 289 + st_len;
    int  n_done = 0;
    bit  v;
    int  s, b;
    @(negedge clk);
    start = 1'b1;
    for (int c = 0; c <= dc + 2; c++) begin
      @(posedge clk);
      #1;
      exp_issue(c, st_edge, st_len, v, s, b);
      check($sformatf("issue_valid@%0d", c), 32'(issue_valid), 32'(v));
      if (v) begin
        check($sformatf("issue_stage@%0d", c), 32'(issue_stage), 32'(s));
        check($sformatf("issue_beat@%0d", c), 32'(issue_beat), 32'(b));
        check($sformatf("tw_idx@%0d", c), 32'(tw_idx), 32'((b << s) % 16));
        if (s == 3 && b == 5) check("tw_s3_b5", 32'(tw_idx), 32'd8);
        if (s == 11) check($sformatf("tw_s11@%0d", c), 32'(tw_idx), 32'd0);
      end
      exp_issue(c - 8, st_edge, st_len, v, s, b);
      check($sformatf("wb_valid@%0d", c), 32'(wb_valid), 32'(v));
      if (v) begin
        check($sformatf("wb_stage@%0d", c), 32'(wb_stage), 32'(s));
        check($sformatf("wb_beat@%0d", c), 32'(wb_beat), 32'(b));
      end
      check($sformatf("done@%0d", c), 32'(done), 32'(c == dc));
      check($sformatf("busy@%0d", c), 32'(busy), 32'(c < dc));
      if (done) n_done++;
      @(negedge clk);
      start = extra_starts && (c + 1 == 50 || c + 1 == 150);
      stall = (st_len > 0) && (c + 1 >= st_edge) && (c + 1 < st_edge + st_len);
    end
    start = 1'b0;
    stall = 1'b0;
    check("done_pulse_count", 32'(n_done), 32'd1);
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    stall = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_issue_valid", 32'(issue_valid), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Plain pass: issues 1-16, 25-40 ... last at 280, done at 289.
    run_pass(0, 0, 1'b0);

    // Stall sampled on edges 6-8: beat 4 at 5, beat 5 at 9, stage 0 ends at 19, done at 292.
    run_pass(6, 3, 1'b0);

    // Starts at 50 and 150 while busy are ignored.
    run_pass(0, 0, 1'b1);

    // Abort sampled at edge 100: everything quiet from then on.
    @(negedge clk);
    start = 1'b1;
    for (int c = 0; c <= 300; c++) begin
      @(posedge clk);
      #1;
      if (c == 99) check("pre_abort_busy", 32'(busy), 32'd1);
      if (c >= 100) begin
        check($sformatf("abort_busy@%0d", c), 32'(busy), 32'd0);
        check($sformatf("abort_issue@%0d", c), 32'(issue_valid), 32'd0);
        check($sformatf("abort_wb@%0d", c), 32'(wb_valid), 32'd0);
        check($sformatf("abort_done@%0d", c), 32'(done), 32'd0);
      end
      @(negedge clk);
      start = 1'b0;
      abort = (c + 1 == 100);
    end
    abort = 1'b0;
    run_pass(0, 0, 1'b0);

    // Start and abort together while idle: stays idle.
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("start_abort_busy@%0d", c), 32'(busy), 32'd0);
      check($sformatf("start_abort_issue@%0d", c), 32'(issue_valid), 32'd0);
    end

    // Async reset mid-cycle during stage 5 drain (cycle 140).
    @(negedge clk);
    start = 1'b1;
    for (int c = 0; c <= 140; c++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      start = 1'b0;
      if (c == 139) break;
    end
    @(posedge clk);
    #1;
    check("drain5_busy", 32'(busy), 32'd1);
    check("drain5_issue", 32'(issue_valid), 32'd0);
    check("drain5_wb_valid", 32'(wb_valid), 32'd1);
    check("drain5_wb_stage", 32'(wb_stage), 32'd5);
    check("drain5_wb_beat", 32'(wb_beat), 32'd11);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_wb_valid", 32'(wb_valid), 32'd0);
    check("async_rst_wb_tag", 32'({wb_stage, wb_beat}), 32'd0);
    check("async_rst_issue", 32'({issue_valid, issue_stage, issue_beat, tw_idx}), 32'd0);
    check("async_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      stall = c[0];
      @(posedge clk);
      #1;
      check($sformatf("post_rst_busy@%0d", c), 32'(busy), 32'd0);
      check($sformatf("post_rst_issue@%0d", c), 32'(issue_valid), 32'd0);
      check($sformatf("post_rst_wb@%0d", c), 32'(wb_valid), 32'd0);
    end
    @(negedge clk);
    stall = 1'b0;
    run_pass(0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
